// File: rtl/perceptron_train_ctrl.sv
// perceptron_train_ctrl: epoch/sample sequencer for the perceptron weight/bias datapath.
// Runs epochs over N_SAMPLES samples and pulses per-sample load enables on misclassification.
// Stops when an epoch contains no update (converged).
// Optional feature macro: PTC_EPOCH_LIMIT_EN. When it is defined, training also stops after
// MAX_EPOCHS updating epochs (timeout). When it is undefined, timeout is tied low.
module perceptron_train_ctrl #(
    parameter int N_SAMPLES  = 4,
    parameter int N_WEIGHTS  = 2,
    parameter int MAX_EPOCHS = 16,
    localparam int SW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
    localparam int EW = $clog2(MAX_EPOCHS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 update,
    output logic                 ready,
    output logic [SW-1:0]        sample_idx,
    output logic [EW-1:0]        epoch_cnt,
    output logic                 init_params,
    output logic [N_WEIGHTS-1:0] ld_w,
    output logic                 ld_b,
    output logic                 enable_test,
    output logic                 converged,
    output logic                 timeout
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        INIT,
        EPOCH,
        EVAL,
        NEXT,
        CHECK,
        TEST
    } state_t;

    localparam logic [SW-1:0] LAST_SAMPLE = SW'(N_SAMPLES - 1);
`ifdef PTC_EPOCH_LIMIT_EN
    localparam logic [EW-1:0] EPOCH_SAT  = EW'(MAX_EPOCHS);
    localparam logic [EW-1:0] EPOCH_LAST = EW'(MAX_EPOCHS - 1);
`else
    localparam logic [EW-1:0] EPOCH_SAT  = '1;
`endif

    state_t        state_q, state_d;
    logic [SW-1:0] sample_idx_q, sample_idx_d;
    logic [EW-1:0] epoch_cnt_q, epoch_cnt_d;
    logic          flag_q, flag_d;
    logic          converged_q, converged_d;
`ifdef PTC_EPOCH_LIMIT_EN
    logic          timeout_q, timeout_d;
`endif

    // Next-state and counter/status update logic.
    always_comb begin
        state_d      = state_q;
        sample_idx_d = sample_idx_q;
        epoch_cnt_d  = epoch_cnt_q;
        flag_d       = flag_q;
        converged_d  = converged_q;
`ifdef PTC_EPOCH_LIMIT_EN
        timeout_d    = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = ARM;
            end
            ARM: begin
                // Training begins on the falling edge of start.
                if (!start) state_d = INIT;
            end
            INIT: begin
                epoch_cnt_d = '0;
                converged_d = 1'b0;
`ifdef PTC_EPOCH_LIMIT_EN
                timeout_d   = 1'b0;
`endif
                state_d     = EPOCH;
            end
            EPOCH: begin
                sample_idx_d = '0;
                flag_d       = 1'b0;
                state_d      = EVAL;
            end
            EVAL: begin
                if (update) flag_d = 1'b1;
                state_d = NEXT;
            end
            NEXT: begin
                if (sample_idx_q == LAST_SAMPLE) begin
                    state_d = CHECK;
                end else begin
                    sample_idx_d = sample_idx_q + SW'(1);
                    state_d      = EVAL;
                end
            end
            CHECK: begin
                if (!flag_q) begin
                    converged_d = 1'b1;
                    state_d     = TEST;
                end else begin
                    if (epoch_cnt_q != EPOCH_SAT) epoch_cnt_d = epoch_cnt_q + EW'(1);
                    state_d = EPOCH;
`ifdef PTC_EPOCH_LIMIT_EN
                    // Compare the pre-increment count so the limit hits on the MAX_EPOCHS-th epoch.
                    if (epoch_cnt_q == EPOCH_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = TEST;
                    end
`endif
                end
            end
            TEST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sample_idx_q <= '0;
            epoch_cnt_q  <= '0;
            flag_q       <= 1'b0;
            converged_q  <= 1'b0;
`ifdef PTC_EPOCH_LIMIT_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sample_idx_q <= sample_idx_d;
            epoch_cnt_q  <= epoch_cnt_d;
            flag_q       <= flag_d;
            converged_q  <= converged_d;
`ifdef PTC_EPOCH_LIMIT_EN
            timeout_q    <= timeout_d;
`endif
        end
    end

    // Output decode: state-based enables plus Mealy load enables in EVAL.
    always_comb begin
        ready       = (state_q == IDLE);
        init_params = (state_q == INIT);
        enable_test = (state_q == TEST);
        ld_b        = (state_q == EVAL) && update;
        ld_w        = ((state_q == EVAL) && update) ? '1 : '0;
        sample_idx  = sample_idx_q;
        epoch_cnt   = epoch_cnt_q;
        converged   = converged_q;
`ifdef PTC_EPOCH_LIMIT_EN
        timeout     = timeout_q;
`else
        timeout     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Directed bench for perceptron_train_ctrl: three instances (defaults, single-sample, short limit).
module tb_perceptron_train_ctrl;

`ifdef PTC_EPOCH_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] start_v;
    logic [2:0] update_v;
    int         sel;
    int unsigned n_checks;
    int unsigned n_errors;

    // Instance 0: defaults
    logic       ready0, init0, ldb0, test0, conv0, to0;
    logic [1:0] idx0, ldw0;
    logic [4:0] ecnt0;
    // Instance 1: N_SAMPLES=1, N_WEIGHTS=3
    logic       ready1, init1, ldb1, test1, conv1, to1;
    logic [0:0] idx1;
    logic [2:0] ldw1;
    logic [4:0] ecnt1;
    // Instance 2: MAX_EPOCHS=3
    logic       ready2, init2, ldb2, test2, conv2, to2;
    logic [1:0] idx2, ldw2, ecnt2;

    perceptron_train_ctrl #(.N_SAMPLES(4), .N_WEIGHTS(2), .MAX_EPOCHS(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .update(update_v[0]),
        .ready(ready0), .sample_idx(idx0), .epoch_cnt(ecnt0), .init_params(init0),
        .ld_w(ldw0), .ld_b(ldb0), .enable_test(test0), .converged(conv0), .timeout(to0)
    );

    perceptron_train_ctrl #(.N_SAMPLES(1), .N_WEIGHTS(3), .MAX_EPOCHS(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .update(update_v[1]),
        .ready(ready1), .sample_idx(idx1), .epoch_cnt(ecnt1), .init_params(init1),
        .ld_w(ldw1), .ld_b(ldb1), .enable_test(test1), .converged(conv1), .timeout(to1)
    );

    perceptron_train_ctrl #(.N_SAMPLES(4), .N_WEIGHTS(2), .MAX_EPOCHS(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .update(update_v[2]),
        .ready(ready2), .sample_idx(idx2), .epoch_cnt(ecnt2), .init_params(init2),
        .ld_w(ldw2), .ld_b(ldb2), .enable_test(test2), .converged(conv2), .timeout(to2)
    );

    logic [31:0] o_ready, o_init, o_ldb, o_test, o_conv, o_to, o_idx, o_ecnt, o_ldw;

    // Route the selected instance's outputs onto common 32-bit views.
    always_comb begin
        case (sel)
            1: begin
                o_ready = 32'(ready1); o_init = 32'(init1); o_ldb = 32'(ldb1);
                o_test  = 32'(test1);  o_conv = 32'(conv1); o_to  = 32'(to1);
                o_idx   = 32'(idx1);   o_ecnt = 32'(ecnt1); o_ldw = 32'(ldw1);
            end
            2: begin
                o_ready = 32'(ready2); o_init = 32'(init2); o_ldb = 32'(ldb2);
                o_test  = 32'(test2);  o_conv = 32'(conv2); o_to  = 32'(to2);
                o_idx   = 32'(idx2);   o_ecnt = 32'(ecnt2); o_ldw = 32'(ldw2);
            end
            default: begin
                o_ready = 32'(ready0); o_init = 32'(init0); o_ldb = 32'(ldb0);
                o_test  = 32'(test0);  o_conv = 32'(conv0); o_to  = 32'(to0);
                o_idx   = 32'(idx0);   o_ecnt = 32'(ecnt0); o_ldw = 32'(ldw0);
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (dut %0d, t=%0t): got %0h expected %0h", tag, sel, $time, got, exp);
        end
    endtask

    // One training run on the selected instance. pat bit (4*epoch + sample) = update for that EVAL.
    // exp_len counts cycles from INIT (cycle 1) through TEST inclusive.
    task automatic run_train(input int ns, input int nw, input int max_ep, input logic [31:0] pat,
                             input int hold, input bit toggle, input bit expect_end,
                             input int n_ep_cap, input int exp_len, input bit exp_conv,
                             input bit exp_to);
        int          cnt;
        int          cyc;
        bit          any;
        bit          done;
        bit          u;
        logic [31:0] mask;
        cnt  = 0;
        done = 1'b0;
        mask = (32'd1 << nw) - 32'd1;
        start_v[sel] = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("arm_ready", o_ready, 0);
            check("arm_init", o_init, 0);
            check("arm_ldw", o_ldw, 0);
        end
        start_v[sel] = 1'b0;
        @(negedge clk);
        cyc = 1;
        check("init_pulse", o_init, 1);
        check("init_ready", o_ready, 0);
        for (int e = 0; e < n_ep_cap && !done; e++) begin
            any = 1'b0;
            @(negedge clk);
            cyc++;
            check("epoch_init", o_init, 0);
            check("epoch_conv", o_conv, 0);
            check("epoch_to", o_to, 0);
            check("epoch_test", o_test, 0);
            check("epoch_ldw", o_ldw, 0);
            for (int s = 0; s < ns; s++) begin
                @(negedge clk);
                cyc++;
                u = pat[e*4+s];
                update_v[sel] = u;
                if (toggle) start_v[sel] = (s % 2 == 0);
                any |= u;
                #1;
                check("eval_idx", o_idx, 32'(s));
                check("eval_ldw", o_ldw, u ? mask : 32'd0);
                check("eval_ldb", o_ldb, 32'(u));
                @(negedge clk);
                cyc++;
                update_v[sel] = 1'b1;
                #1;
                check("next_idx", o_idx, 32'(s));
                check("next_ldw", o_ldw, 0);
                check("next_ldb", o_ldb, 0);
            end
            @(negedge clk);
            cyc++;
            update_v[sel] = 1'b1;
            #1;
            check("check_ecnt", o_ecnt, 32'(cnt));
            check("check_ldw", o_ldw, 0);
            check("check_test", o_test, 0);
            check("check_ready", o_ready, 0);
            update_v[sel] = 1'b0;
            start_v[sel]  = 1'b0;
            if (!any) begin
                done = 1'b1;
            end else begin
                cnt++;
                if (LIMIT && cnt == max_ep) done = 1'b1;
            end
        end
        if (expect_end) begin
            @(negedge clk);
            cyc++;
            check("test_pulse", o_test, 1);
            check("test_len", 32'(cyc), 32'(exp_len));
            check("test_conv", o_conv, 32'(exp_conv));
            check("test_to", o_to, 32'(exp_to));
            check("test_ldw", o_ldw, 0);
            if (!exp_to) check("test_ecnt", o_ecnt, 32'(cnt));
            @(negedge clk);
            check("idle_ready", o_ready, 1);
            check("idle_test", o_test, 0);
            check("idle_conv", o_conv, 32'(exp_conv));
            check("idle_to", o_to, 32'(exp_to));
        end else begin
            @(negedge clk);
            check("noend_test", o_test, 0);
            check("noend_ready", o_ready, 0);
            check("noend_ecnt", o_ecnt, 32'(cnt));
            check("noend_to", o_to, 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        sel      = 0;
        start_v  = '0;
        update_v = '0;
        rst_n    = 1'b0;

        // Outputs during reset, all instances
        #1;
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            check("rst_ready", o_ready, 1);
            check("rst_init", o_init, 0);
            check("rst_test", o_test, 0);
            check("rst_ecnt", o_ecnt, 0);
            check("rst_to", o_to, 0);
        end
        sel = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-EVAL with update high aborts immediately
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        check("arm_ready_drop", o_ready, 0);
        start_v[0] = 1'b0;
        @(negedge clk);
        check("rst_run_init", o_init, 1);
        @(negedge clk);
        @(negedge clk);
        update_v[0] = 1'b1;
        #1;
        check("rst_run_eval_ldw", o_ldw, 32'h3);
        rst_n = 1'b0;
        #1;
        check("rst_async_ready", o_ready, 1);
        check("rst_async_ldw", o_ldw, 0);
        check("rst_async_ldb", o_ldb, 0);
        check("rst_async_test", o_test, 0);
        update_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_ready", o_ready, 1);
            check("post_rst_test", o_test, 0);
            check("post_rst_idx", o_idx, 0);
            check("post_rst_ecnt", o_ecnt, 0);
            check("post_rst_conv", o_conv, 0);
        end

        // Converge in first epoch: 1 + 10 + 1 = 12 cycles
        run_train(4, 2, 16, 32'h0, 1, 1'b0, 1'b1, 8, 12, 1'b1, 1'b0);
        // Two epochs, update on sample 2 of epoch 0: 1 + 10 + 10 + 1 = 22 cycles
        run_train(4, 2, 16, 32'h4, 1, 1'b0, 1'b1, 8, 22, 1'b1, 1'b0);
        // start held 10 cycles, toggled during EVAL
        run_train(4, 2, 16, 32'h0, 10, 1'b1, 1'b1, 8, 12, 1'b1, 1'b0);

        // Single sample, three weights: update in epoch 0 only: 1 + 4 + 4 + 1 = 10 cycles
        sel = 1;
        @(negedge clk);
        run_train(1, 3, 16, 32'h1, 1, 1'b0, 1'b1, 8, 10, 1'b1, 1'b0);

        // Always updating on the MAX_EPOCHS=3 instance
        sel = 2;
        @(negedge clk);
`ifdef PTC_EPOCH_LIMIT_EN
        run_train(4, 2, 3, 32'hFFF, 1, 1'b0, 1'b1, 3, 32, 1'b0, 1'b1);
`else
        run_train(4, 2, 3, 32'hFFF, 1, 1'b0, 1'b0, 3, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", o_ready, 1);
        check("abort_to", o_to, 0);
        check("abort_ecnt", o_ecnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/perceptron_train_ctrl.md
# perceptron_train_ctrl

Parametrised training-sequence controller for the perceptron node: it sequences the weight/bias datapath through repeated epochs over `N_SAMPLES` training samples. It generates per-sample load enables for `N_WEIGHTS` weights plus bias and stops on convergence (an epoch with no update) or, when enabled, on an epoch limit. It contains its own sample and epoch counters, so the datapath no longer needs an external counter or update flag. It sits between the top-level start/ready handshake and the perceptron weight/bias registers.

## Interface
- `N_SAMPLES`, default 4: training samples per epoch, ≥1.
- `N_WEIGHTS`, default 2: number of weight registers driven, ≥1.
- `MAX_EPOCHS`, default 16: epoch limit, ≥1. Used only with `PTC_EPOCH_LIMIT_EN`.
- Derived widths:
  - `SW` = max(1, $clog2(N_SAMPLES)).
  - `EW` = $clog2(MAX_EPOCHS+1).

Ports:
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: training request, level; training begins on its falling edge.
- `update` in 1: from datapath, current sample misclassified; sampled in EVAL only.
- `ready` out 1: controller idle, accepts `start`.
- `sample_idx` out SW: index of the sample currently presented to the datapath.
- `epoch_cnt` out EW: completed epochs that contained ≥1 update.
- `init_params` out 1: clear weights and bias.
- `ld_w` out N_WEIGHTS: per-weight load enables.
- `ld_b` out 1: bias load enable.
- `enable_test` out 1: one-cycle pulse that starts the test phase.
- `converged` out 1: sticky status, last run ended with an update-free epoch.
- `timeout` out 1: sticky status, last run hit `MAX_EPOCHS`.

## Operation
- States: IDLE, ARM, INIT, EPOCH, EVAL, NEXT, CHECK, TEST.
- Internal `flag` register records whether any update occurred in the current epoch.
- IDLE:
  - `ready`=1.
  - `start`=1 → ARM; otherwise stay.
- ARM: stay while `start`=1; `start`=0 → INIT.
- INIT:
  - `init_params`=1.
  - Clear `epoch_cnt`, `converged`, `timeout`.
  - → EPOCH.
- EPOCH: `sample_idx`←0, `flag`←0 → EVAL.
- EVAL:
  - If `update`=1: `ld_w`=all ones, `ld_b`=1, `flag`←1 (Mealy, same cycle).
  - → NEXT.
- NEXT:
  - `sample_idx`==N_SAMPLES-1 → CHECK.
  - Otherwise `sample_idx`←`sample_idx`+1 → EVAL.
- CHECK:
  - `flag`=0: `converged`←1 → TEST.
  - `flag`=1: `epoch_cnt`←`epoch_cnt`+1, then → EPOCH, except with the epoch limit enabled and `epoch_cnt`+1==MAX_EPOCHS: `timeout`←1 → TEST.
- TEST: `enable_test`=1 → IDLE.
- All enables are 0 outside the states listed above. `ld_w`/`ld_b` are never asserted outside EVAL.
- `start` is ignored in every state except IDLE and ARM.
- `update` outside EVAL has no effect.
- `N_SAMPLES`=1: NEXT always goes to CHECK; `sample_idx` stays 0.
- `converged` and `timeout` are mutually exclusive. Both hold until the next INIT.
- `epoch_cnt` saturates at MAX_EPOCHS and never wraps.

## Timing
- Reset (async assert): state IDLE; `sample_idx`, `epoch_cnt`, `flag`, `converged`, `timeout` = 0.
  - Outputs during reset: `ready`=1, all enables 0.
  - Reset mid-run aborts immediately, with no `enable_test` pulse.
- Release is synchronous to `clk`: first transition on the first rising edge with `rst_n`=1.
- One epoch = 2·N_SAMPLES+2 cycles (EPOCH, N×(EVAL,NEXT), CHECK).
- From the cycle after ARM sees `start`=0: INIT (1) + k epochs + TEST (1), then IDLE.
- `ready` drops the cycle after `start` is sampled high in IDLE.
- `ready` returns the cycle after TEST.

## Configuration
- `PTC_EPOCH_LIMIT_EN` defined:
  - CHECK enforces `MAX_EPOCHS`.
  - `timeout` can assert.
- `PTC_EPOCH_LIMIT_EN` undefined:
  - Training runs until convergence (a non-separable set never terminates).
  - `timeout` is tied to 0.
  - `epoch_cnt` still counts and saturates at its all-ones value.

## Test plan
- Reset then idle: `rst_n`=0 mid-EVAL with `update`=1 → same cycle `ready`=1, `ld_w`=0; after release, state IDLE and all counters 0.
- Converge in the first epoch (defaults): `start` pulse 1 cycle, `update`=0 → `init_params` once; `sample_idx` 0,1,2,3; `enable_test` exactly 12 cycles after INIT; `converged`=1, `epoch_cnt`=0.
- Two-epoch run: `update`=1 only on sample 2 of epoch 0 → `ld_w`=2'b11 and `ld_b`=1 exactly in that EVAL cycle; `epoch_cnt`=1; `converged`=1 after epoch 1.
- Timeout (`PTC_EPOCH_LIMIT_EN`, MAX_EPOCHS=3): `update`=1 always → `enable_test` after 3 epochs; `timeout`=1, `converged`=0, `epoch_cnt`=2 seen in the final CHECK.
- `start` held high 10 cycles → controller stays in ARM, no enables; INIT on the first cycle after `start` falls. `start` toggling during EVAL is ignored.
- `N_SAMPLES`=1, `N_WEIGHTS`=3: `update`=1 in the first epoch only → `ld_w`=3'b111 once; epoch length 4 cycles; converged after the second epoch.
